// File: rtl/hsid_min_dist_sel.sv
// Minimum/maximum distance selector: tracks the extreme accumulated distances over one
// pixel's library sweep and presents them on a valid/ready result register.
module hsid_min_dist_sel #(
    parameter  int DATA_WIDTH_ACC        = 48,
    parameter  int HSI_LIBRARY_SIZE      = 256,
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
    input  logic                             acc_valid,
    input  logic [DATA_WIDTH_ACC-1:0]        acc_value,
    input  logic                             acc_last,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] acc_ref,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [DATA_WIDTH_ACC-1:0]        min_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref,
    output logic [DATA_WIDTH_ACC-1:0]        max_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_ref,
    output logic                             busy,
    output logic                             overrun,
    output logic                             ref_mismatch
);

    localparam int AW = HSI_LIBRARY_SIZE_ADDR;
    localparam int SW = AW + 1;  // one extra bit so a full-size sweep is representable

    logic [AW-1:0]             ref_cnt_q, ref_cnt_d;
    logic [SW-1:0]             size_q, size_d;
    logic [DATA_WIDTH_ACC-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [AW-1:0]             run_min_ref_q, run_min_ref_d, run_max_ref_q, run_max_ref_d;
    logic                      res_valid_q, res_valid_d;
    logic [DATA_WIDTH_ACC-1:0] res_min_q, res_min_d, res_max_q, res_max_d;
    logic [AW-1:0]             res_min_ref_q, res_min_ref_d, res_max_ref_q, res_max_ref_d;
    logic                      overrun_q, overrun_d, mismatch_q, mismatch_d;

    logic                      ev, first, is_final, accept;
    logic [SW-1:0]             eff_in, cur_size;
    logic [DATA_WIDTH_ACC-1:0] new_min, new_max;
    logic [AW-1:0]             new_min_ref, new_max_ref;

    always_comb begin
        ev       = acc_valid && acc_last && !clear;
        first    = (ref_cnt_q == '0);
        eff_in   = (library_size == '0) ? SW'(HSI_LIBRARY_SIZE) : {1'b0, library_size};
        cur_size = first ? eff_in : size_q;
        is_final = ({1'b0, ref_cnt_q} == (cur_size - SW'(1)));
        accept   = res_valid_q && result_ready;

        // Strict compares so ties keep the earlier reference.
        new_min     = run_min_q;
        new_min_ref = run_min_ref_q;
        new_max     = run_max_q;
        new_max_ref = run_max_ref_q;
        if (first || (acc_value < run_min_q)) begin
            new_min     = acc_value;
            new_min_ref = acc_ref;
        end
        if (first || (acc_value > run_max_q)) begin
            new_max     = acc_value;
            new_max_ref = acc_ref;
        end
    end

    always_comb begin
        ref_cnt_d     = ref_cnt_q;
        size_d        = size_q;
        run_min_d     = run_min_q;
        run_max_d     = run_max_q;
        run_min_ref_d = run_min_ref_q;
        run_max_ref_d = run_max_ref_q;
        res_valid_d   = res_valid_q;
        res_min_d     = res_min_q;
        res_max_d     = res_max_q;
        res_min_ref_d = res_min_ref_q;
        res_max_ref_d = res_max_ref_q;
        overrun_d     = overrun_q;
        mismatch_d    = mismatch_q;

        if (accept) res_valid_d = 1'b0;

        if (clear) begin
            ref_cnt_d     = '0;
            size_d        = '0;
            run_min_d     = '0;
            run_max_d     = '0;
            run_min_ref_d = '0;
            run_max_ref_d = '0;
            overrun_d     = 1'b0;
            mismatch_d    = 1'b0;
        end else if (ev) begin
            if (acc_ref != ref_cnt_q) mismatch_d = 1'b1;
            if (first) size_d = eff_in;
            run_min_d     = new_min;
            run_max_d     = new_max;
            run_min_ref_d = new_min_ref;
            run_max_ref_d = new_max_ref;
            if (is_final) begin
                ref_cnt_d     = '0;
                res_valid_d   = 1'b1;
                res_min_d     = new_min;
                res_max_d     = new_max;
                res_min_ref_d = new_min_ref;
                res_max_ref_d = new_max_ref;
                if (res_valid_q && !result_ready) overrun_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q     <= '0;
            size_q        <= '0;
            run_min_q     <= '0;
            run_max_q     <= '0;
            run_min_ref_q <= '0;
            run_max_ref_q <= '0;
            res_valid_q   <= 1'b0;
            res_min_q     <= '0;
            res_max_q     <= '0;
            res_min_ref_q <= '0;
            res_max_ref_q <= '0;
            overrun_q     <= 1'b0;
            mismatch_q    <= 1'b0;
        end else begin
            ref_cnt_q     <= ref_cnt_d;
            size_q        <= size_d;
            run_min_q     <= run_min_d;
            run_max_q     <= run_max_d;
            run_min_ref_q <= run_min_ref_d;
            run_max_ref_q <= run_max_ref_d;
            res_valid_q   <= res_valid_d;
            res_min_q     <= res_min_d;
            res_max_q     <= res_max_d;
            res_min_ref_q <= res_min_ref_d;
            res_max_ref_q <= res_max_ref_d;
            overrun_q     <= overrun_d;
            mismatch_q    <= mismatch_d;
        end
    end

    assign result_valid = res_valid_q;
    assign min_value    = res_min_q;
    assign min_ref      = res_min_ref_q;
    assign max_value    = res_max_q;
    assign max_ref      = res_max_ref_q;
    assign busy         = (ref_cnt_q != '0);
    assign overrun      = overrun_q;
    assign ref_mismatch = mismatch_q;

endmodule

// File: tb/tb_hsid_min_dist_sel.sv
// Directed testbench for hsid_min_dist_sel with hand-computed expectations.
module tb_hsid_min_dist_sel;

    logic        clk = 1'b0;
    logic        rst, clear, acc_valid, acc_last, result_ready;
    logic [7:0]  library_size, acc_ref;
    logic [47:0] acc_value;
    logic        result_valid, busy, overrun, ref_mismatch;
    logic [47:0] min_value, max_value;
    logic [7:0]  min_ref, max_ref;

    int tests = 0;
    int fails = 0;

    hsid_min_dist_sel dut (
        .clk(clk), .rst(rst), .clear(clear), .library_size(library_size),
        .acc_valid(acc_valid), .acc_value(acc_value), .acc_last(acc_last), .acc_ref(acc_ref),
        .result_valid(result_valid), .result_ready(result_ready),
        .min_value(min_value), .min_ref(min_ref), .max_value(max_value), .max_ref(max_ref),
        .busy(busy), .overrun(overrun), .ref_mismatch(ref_mismatch)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read on the falling edge too.
    task automatic send_ev(input logic [7:0] r, input logic [47:0] v);
        @(negedge clk);
        acc_valid = 1'b1; acc_last = 1'b1; acc_ref = r; acc_value = v;
        @(negedge clk);
        acc_valid = 1'b0; acc_last = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({result_valid, busy, overrun, ref_mismatch} !== 4'b0) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {result_valid, busy, overrun, ref_mismatch});
        end
        tests++;
        if ({min_value, min_ref, max_value, max_ref} !== '0) begin
            fails++; $display("FAIL reset_fields got %h/%0d/%h/%0d want 0", min_value, min_ref, max_value, max_ref);
        end
    endtask

    task automatic test_basic();
        library_size = 8'd4;
        send_ev(0, 50);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_mid got %b want 1", busy); end
        send_ev(1, 20); send_ev(2, 90); send_ev(3, 20);
        tests++;
        if (result_valid !== 1'b1 || min_value !== 48'd20 || min_ref !== 8'd1 ||
            max_value !== 48'd90 || max_ref !== 8'd2) begin
            fails++; $display("FAIL basic_result got v=%b min=%0d/%0d max=%0d/%0d want 1 20/1 90/2",
                              result_valid, min_value, min_ref, max_value, max_ref);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b want 0", busy); end
        consume();
        tests++;
        if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_consumed got %b want 0", result_valid); end
    endtask

    task automatic test_hold();
        int bad = 0;
        send_ev(0, 50); send_ev(1, 20); send_ev(2, 90); send_ev(3, 20);
        repeat (10) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || min_value !== 48'd20 || min_ref !== 8'd1 ||
                max_value !== 48'd90 || max_ref !== 8'd2) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        consume();
        tests++;
        if (result_valid !== 1'b0) begin fails++; $display("FAIL hold_drop got %b want 0", result_valid); end
    endtask

    task automatic test_overrun();
        library_size = 8'd2;
        send_ev(0, 5); send_ev(1, 9);
        tests++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_first got %b want 0", overrun); end
        send_ev(0, 7); send_ev(1, 3);
        tests++;
        if (min_value !== 48'd3 || min_ref !== 8'd1 || max_value !== 48'd7 || max_ref !== 8'd0) begin
            fails++; $display("FAIL ovr_result got min=%0d/%0d max=%0d/%0d want 3/1 7/0",
                              min_value, min_ref, max_value, max_ref);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (overrun !== 1'b1 || result_valid !== 1'b1) begin
            fails++; $display("FAIL ovr_sticky got ovr=%b v=%b want 1 1", overrun, result_valid);
        end
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        tests++;
        if (overrun !== 1'b0 || result_valid !== 1'b1 || min_value !== 48'd3) begin
            fails++; $display("FAIL ovr_clear got ovr=%b v=%b min=%0d want 0 1 3", overrun, result_valid, min_value);
        end
        consume();
    endtask

    task automatic test_full_size();
        library_size = 8'd0;
        for (int i = 0; i < 256; i++) send_ev(8'(i), 48'(1000 - i));
        tests++;
        if (result_valid !== 1'b1 || min_value !== 48'd745 || min_ref !== 8'd255 ||
            max_value !== 48'd1000 || max_ref !== 8'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL full_result got v=%b min=%0d/%0d max=%0d/%0d busy=%b want 1 745/255 1000/0 0",
                              result_valid, min_value, min_ref, max_value, max_ref, busy);
        end
        consume();
    endtask

    task automatic test_partial_and_mismatch();
        library_size = 8'd4;
        send_ev(0, 50);
        @(negedge clk); acc_valid = 1'b1; acc_last = 1'b0; acc_value = 48'd1; acc_ref = 8'd1;
        @(negedge clk); acc_valid = 1'b0;
        send_ev(1, 60);
        @(negedge clk); acc_last = 1'b1; acc_value = 48'd1; acc_ref = 8'd2;
        @(negedge clk); acc_last = 1'b0;
        tests++;
        if (ref_mismatch !== 1'b0 || result_valid !== 1'b0) begin
            fails++; $display("FAIL partial_nomis got mis=%b v=%b want 0 0", ref_mismatch, result_valid);
        end
        send_ev(5, 70);
        tests++;
        if (ref_mismatch !== 1'b1) begin fails++; $display("FAIL mismatch_set got %b want 1", ref_mismatch); end
        send_ev(3, 80);
        tests++;
        if (result_valid !== 1'b1 || min_value !== 48'd50 || min_ref !== 8'd0 ||
            max_value !== 48'd80 || max_ref !== 8'd3) begin
            fails++; $display("FAIL partial_result got v=%b min=%0d/%0d max=%0d/%0d want 1 50/0 80/3",
                              result_valid, min_value, min_ref, max_value, max_ref);
        end
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        tests++;
        if (ref_mismatch !== 1'b0) begin fails++; $display("FAIL mismatch_clear got %b want 0", ref_mismatch); end
        consume();
    endtask

    task automatic test_clear_and_rst();
        library_size = 8'd4;
        send_ev(0, 10); send_ev(1, 20);
        @(negedge clk);
        clear = 1'b1; acc_valid = 1'b1; acc_last = 1'b1; acc_ref = 8'd2; acc_value = 48'd5;
        @(negedge clk);
        clear = 1'b0; acc_valid = 1'b0; acc_last = 1'b0;
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++; $display("FAIL clear_drop got busy=%b v=%b want 0 0", busy, result_valid);
        end
        send_ev(0, 40); send_ev(1, 30); send_ev(2, 60); send_ev(3, 35);
        tests++;
        if (result_valid !== 1'b1 || min_value !== 48'd30 || min_ref !== 8'd1 ||
            max_value !== 48'd60 || max_ref !== 8'd2 || ref_mismatch !== 1'b0) begin
            fails++; $display("FAIL clear_next got v=%b min=%0d/%0d max=%0d/%0d mis=%b want 1 30/1 60/2 0",
                              result_valid, min_value, min_ref, max_value, max_ref, ref_mismatch);
        end
        send_ev(0, 11); send_ev(7, 12);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tests++;
        if ({result_valid, busy, overrun, ref_mismatch} !== 4'b0 ||
            {min_value, min_ref, max_value, max_ref} !== '0) begin
            fails++; $display("FAIL rst_mid got v=%b busy=%b ovr=%b mis=%b min=%0d max=%0d want all 0",
                              result_valid, busy, overrun, ref_mismatch, min_value, max_value);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; acc_valid = 1'b0; acc_last = 1'b0; result_ready = 1'b0;
        library_size = 8'd0; acc_ref = 8'd0; acc_value = 48'd0;
        test_reset();
        test_basic();
        test_hold();
        test_overrun();
        test_full_size();
        test_partial_and_mismatch();
        test_clear_and_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
